store_req_ctrl: RTL and testbench
=================================

Name: store_req_ctrl

Overview:
- Store-side data-bus master in the MEM stage; write-direction counterpart of the load-path byte/halfword extraction.
- Converts SB/SH/SW into an aligned 32-bit write word, byte strobes and transfer size, then drives one sram-like write transaction (req / addr_ok / data_ok).
- Stalls the pipeline until the write is acknowledged.
- Flags store address-error exceptions (AdES) before any bus request is issued.

Parameters:
- ADDR_W, 32, width of memory address and of the badvaddr output.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- storeM  input  1  MEM-stage instruction is a valid store
- alucontrolM  input  8  op code: `EXE_SB_OP / `EXE_SH_OP / `EXE_SW_OP
- aluoutM  input  ADDR_W  effective store address
- writedataM  input  32  rt register value
- flushM  input  1  exception/flush on MEM stage this cycle
- adesM  output  1  store address error (combinational)
- badvaddrM  output  ADDR_W  faulting address, equals aluoutM when adesM=1, else 0
- stallM  output  1  hold the pipeline (combinational)
- data_req  output  1  bus request
- data_wr  output  1  write flag, 1 whenever data_req=1
- data_size  output  2  0 = byte, 1 = half, 2 = word
- data_addr  output  ADDR_W  byte address
- data_wdata  output  32  lane-replicated write data
- data_wstrb  output  4  byte enables
- data_addr_ok  input  1  slave accepted request
- data_data_ok  input  1  write completed

Behaviour:
- Alignment (combinational, from aluoutM / writedataM):
  - SB: wdata = {4{rt[7:0]}}; wstrb = 4'b0001 << addr[1:0]; size = 0; never faults.
  - SH: wdata = {2{rt[15:0]}}; wstrb = addr[1] ? 1100 : 0011; size = 1; addr[0] = 1 → adesM.
  - SW: wdata = rt; wstrb = 1111; size = 2; addr[1:0] ≠ 0 → adesM.
  - Any other alucontrolM: not a store; no request; adesM = 0.
- adesM is asserted only when storeM = 1 and the op is SH/SW with misaligned address; it is independent of flushM.
- Start condition: storeM & valid store op & ~adesM & ~flushM & state = IDLE.
- FSM states: IDLE, ADDR, DATA.
  - IDLE → ADDR on start. The same edge registers addr, wdata, wstrb and size into the output registers.
  - ADDR: data_req = 1.
    - On addr_ok & data_ok in the same cycle → IDLE.
    - On addr_ok alone → DATA.
    - Otherwise hold, with all request fields stable.
  - DATA: data_req = 0; → IDLE on data_ok.
  - A data_ok seen in IDLE is ignored.
- Request timing: data_req first rises the cycle after start. Bus outputs are registered; they hold the captured values from ADDR until the next start and are 0 after reset.
- stallM = start | (state = ADDR) | (state = DATA & ~data_ok).
  - Deasserted in the cycle the completing data_ok arrives, so the store retires exactly once.
  - Minimum stall for a store is 2 cycles (start cycle plus one ADDR cycle with addr_ok & data_ok).
- Flush rules:
  - flushM in IDLE suppresses start.
  - flushM in ADDR/DATA is ignored. An issued request is never withdrawn, and the transaction runs to data_ok.
- Reset (including mid-transaction) takes effect at the next clk edge:
  - state → IDLE.
  - data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb → 0.
  - stallM follows its equation, so it is 0 unless a start condition is present.
- adesM and badvaddrM are combinational and have no reset state.
- Only one outstanding transaction at a time; a new store cannot start until the FSM is back in IDLE.

Test Plan:
- SB, addr = 0x80000003, rt = 0x12345678, addr_ok and data_ok in the first ADDR cycle → wdata = 0x78787878, wstrb = 1000, size = 0; stallM high 2 cycles; single req pulse.
- SH, addr = 0x00001002, rt = 0xABCDBEEF, addr_ok delayed 3 cycles, data_ok 2 cycles later → wstrb = 1100, wdata = 0xBEEFBEEF; addr/wdata stable while waiting; stallM drops in the data_ok cycle.
- SW, addr = 0x00000006 → adesM = 1, badvaddrM = 0x00000006, data_req never asserted, stallM = 0. Repeat with SH at 0x00000005 → same result.
- SW, addr = 0x00000010, flushM = 1 in the start cycle → no request, stallM = 0. flushM asserted instead during ADDR → request still completes on data_ok.
- rst asserted while in DATA → next cycle: state IDLE, data_req = 0, outputs zero, stallM = 0. A late data_ok afterwards causes no state change.
- Two back-to-back SW (0x100, 0x104) → two distinct transactions, the second req starts only after the first data_ok; exactly two addr_ok handshakes observed.

Source files
------------

// File: rtl/store_req_ctrl.sv
// store_req_ctrl: MEM-stage store master; aligns SB/SH/SW into strobed word writes over req/addr_ok/data_ok, stalls until data_ok, flags AdES
module store_req_ctrl #(
  parameter int ADDR_W = 32,
  parameter logic [7:0] SB_OP = 8'b11101000,
  parameter logic [7:0] SH_OP = 8'b11101001,
  parameter logic [7:0] SW_OP = 8'b11101011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              storeM,
  input  logic [7:0]        alucontrolM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [31:0]       writedataM,
  input  logic              flushM,
  output logic              adesM,
  output logic [ADDR_W-1:0] badvaddrM,
  output logic              stallM,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nx;
  logic is_sb, is_sh, is_sw, start;
  logic [31:0] al_wdata;
  logic [3:0] al_wstrb;
  logic [1:0] al_size;
  always_comb begin
    is_sb = alucontrolM == SB_OP;
    is_sh = alucontrolM == SH_OP;
    is_sw = alucontrolM == SW_OP;
    adesM = storeM & ((is_sh & aluoutM[0]) | (is_sw & (aluoutM[1:0] != 2'b00)));
    badvaddrM = adesM ? aluoutM : '0;
    start = storeM & (is_sb | is_sh | is_sw) & ~adesM & ~flushM & (state == IDLE);
    al_wdata = is_sb ? {4{writedataM[7:0]}} : is_sh ? {2{writedataM[15:0]}} : writedataM;
    al_wstrb = is_sb ? 4'b0001 << aluoutM[1:0] : is_sh ? (aluoutM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    al_size = is_sb ? 2'd0 : is_sh ? 2'd1 : 2'd2;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_addr <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
      data_size <= '0;
    end else if (start) begin
      data_addr <= aluoutM;
      data_wdata <= al_wdata;
      data_wstrb <= al_wstrb;
      data_size <= al_size;
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (start ? ADDR : IDLE) :
               state == ADDR ? (data_addr_ok ? (data_data_ok ? IDLE : DATA) : ADDR) :
               (data_data_ok ? IDLE : DATA);
  end
  // stall drops in the data_ok cycle so the store retires exactly once
  always_comb begin
    data_req = state == ADDR;
    data_wr = data_req;
    stallM = start | (state == ADDR) | ((state == DATA) & ~data_data_ok);
  end
endmodule

// File: tb/tb_store_req_ctrl.sv
// tb_store_req_ctrl: directed scenarios plus randomized run against a transaction-level model
module tb_store_req_ctrl;
  localparam logic [7:0] SB = 8'b11101000, SH = 8'b11101001, SW = 8'b11101011, NOP = 8'h20;
  logic clk = 0, rst = 1, storeM = 0, flushM = 0, data_addr_ok = 0, data_data_ok = 0;
  logic [7:0] op = NOP;
  logic [31:0] addr = 0, rt = 0;
  logic adesM, stallM, data_req, data_wr;
  logic [31:0] badvaddrM, data_addr, data_wdata;
  logic [3:0] data_wstrb;
  logic [1:0] data_size;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  store_req_ctrl dut (
    .clk(clk), .rst(rst), .storeM(storeM), .alucontrolM(op), .aluoutM(addr),
    .writedataM(rt), .flushM(flushM), .adesM(adesM), .badvaddrM(badvaddrM),
    .stallM(stallM), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );
  task automatic drive(input logic r, input logic s, input logic [7:0] o, input logic [31:0] a, input logic [31:0] d,
                       input logic f, input logic ao, input logic dk);
    @(negedge clk);
    rst = r; storeM = s; op = o; addr = a; rt = d; flushM = f; data_addr_ok = ao; data_data_ok = dk;
    #1;
  endtask
  task automatic idle(input logic ao = 0, input logic dk = 0);
    drive(0, 0, NOP, 0, 0, 0, ao, dk);
  endtask
  task automatic test_reset;
    drive(1, 0, NOP, 0, 0, 0, 0, 0);
    drive(1, 0, NOP, 0, 0, 0, 0, 0);
    tests++;
    if ({data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, stallM} !== '0) begin
      fails++; $display("FAIL reset: req=%b size=%0d addr=%h wdata=%h wstrb=%b stall=%b, expected all 0",
                        data_req, data_size, data_addr, data_wdata, data_wstrb, stallM);
    end
    idle();
  endtask
  task automatic test_sb;
    drive(0, 1, SB, 32'h80000003, 32'h12345678, 0, 0, 0);
    tests++;
    if ({stallM, data_req, adesM} !== 3'b100) begin
      fails++; $display("FAIL sb_start: stall=%b req=%b ades=%b, expected 1 0 0", stallM, data_req, adesM);
    end
    drive(0, 1, SB, 32'h80000003, 32'h12345678, 0, 1, 1);
    tests++;
    if ({stallM, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb} !== {3'b111, 2'd0, 32'h80000003, 32'h78787878, 4'b1000}) begin
      fails++; $display("FAIL sb_addr: stall=%b req=%b wr=%b size=%0d addr=%h wdata=%h wstrb=%b, expected 1 1 1 0 80000003 78787878 1000",
                        stallM, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb);
    end
    idle();
    tests++;
    if ({stallM, data_req} !== 2'b00 || data_wdata !== 32'h78787878) begin
      fails++; $display("FAIL sb_done: stall=%b req=%b wdata=%h, expected 0 0 78787878", stallM, data_req, data_wdata);
    end
  endtask
  task automatic test_sh_delay;
    drive(0, 1, SH, 32'h00001002, 32'hABCDBEEF, 0, 0, 0);
    tests++;
    if (stallM !== 1'b1 || data_req !== 1'b0) begin
      fails++; $display("FAIL sh_start: stall=%b req=%b, expected 1 0", stallM, data_req);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, SH, 32'h00001002, 32'hABCDBEEF, 0, i == 3, 0);
      tests++;
      if ({stallM, data_req, data_size, data_addr, data_wdata, data_wstrb} !== {2'b11, 2'd1, 32'h00001002, 32'hBEEFBEEF, 4'b1100}) begin
        fails++; $display("FAIL sh_wait%0d: stall=%b req=%b size=%0d addr=%h wdata=%h wstrb=%b, expected 1 1 1 00001002 beefbeef 1100",
                          i, stallM, data_req, data_size, data_addr, data_wdata, data_wstrb);
      end
    end
    drive(0, 1, SH, 32'h00001002, 32'hABCDBEEF, 0, 0, 0);
    tests++;
    if ({stallM, data_req} !== 2'b10) begin
      fails++; $display("FAIL sh_data_wait: stall=%b req=%b, expected 1 0", stallM, data_req);
    end
    drive(0, 1, SH, 32'h00001002, 32'hABCDBEEF, 0, 0, 1);
    tests++;
    if ({stallM, data_req} !== 2'b00) begin
      fails++; $display("FAIL sh_data_ok: stall=%b req=%b, expected 0 0", stallM, data_req);
    end
    idle();
    tests++;
    if ({stallM, data_req} !== 2'b00 || data_wdata !== 32'hBEEFBEEF) begin
      fails++; $display("FAIL sh_after: stall=%b req=%b wdata=%h, expected 0 0 beefbeef", stallM, data_req, data_wdata);
    end
  endtask
  task automatic test_ades;
    logic [7:0] ops [2] = '{SW, SH};
    logic [31:0] as [2] = '{32'h6, 32'h5};
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, ops[i], as[i], 32'hCAFEF00D, 0, 0, 0);
      tests++;
      if ({adesM, stallM, data_req} !== 3'b100 || badvaddrM !== as[i]) begin
        fails++; $display("FAIL ades%0d: ades=%b stall=%b req=%b badv=%h, expected 1 0 0 %h", i, adesM, stallM, data_req, badvaddrM, as[i]);
      end
      idle();
      tests++;
      if ({adesM, stallM, data_req} !== 3'b000 || badvaddrM !== 0) begin
        fails++; $display("FAIL ades_after%0d: ades=%b stall=%b req=%b badv=%h, expected 0 0 0 0", i, adesM, stallM, data_req, badvaddrM);
      end
    end
    drive(0, 0, SW, 32'h6, 0, 0, 0, 0);
    tests++;
    if (adesM !== 1'b0) begin
      fails++; $display("FAIL ades_nostore: ades=%b, expected 0", adesM);
    end
  endtask
  task automatic test_flush;
    drive(0, 1, SW, 32'h10, 32'h11223344, 1, 0, 0);
    tests++;
    if ({stallM, adesM} !== 2'b00) begin
      fails++; $display("FAIL flush_start: stall=%b ades=%b, expected 0 0", stallM, adesM);
    end
    idle();
    tests++;
    if (data_req !== 1'b0) begin
      fails++; $display("FAIL flush_noreq: req=%b, expected 0", data_req);
    end
    drive(0, 1, SW, 32'h12, 0, 1, 0, 0);
    tests++;
    if (adesM !== 1'b1) begin
      fails++; $display("FAIL flush_ades: ades=%b, expected 1", adesM);
    end
    drive(0, 1, SW, 32'h10, 32'h11223344, 0, 0, 0);
    drive(0, 1, SW, 32'h10, 32'h11223344, 1, 0, 0);
    drive(0, 1, SW, 32'h10, 32'h11223344, 1, 1, 0);
    tests++;
    if ({data_req, stallM} !== 2'b11 || data_addr !== 32'h10 || data_wdata !== 32'h11223344) begin
      fails++; $display("FAIL flush_addr: req=%b stall=%b addr=%h wdata=%h, expected 1 1 10 11223344", data_req, stallM, data_addr, data_wdata);
    end
    drive(0, 1, SW, 32'h10, 32'h11223344, 1, 0, 1);
    tests++;
    if ({data_req, stallM} !== 2'b00) begin
      fails++; $display("FAIL flush_done: req=%b stall=%b, expected 0 0", data_req, stallM);
    end
    idle();
  endtask
  task automatic test_reset_mid;
    drive(0, 1, SW, 32'h20, 32'h55AA55AA, 0, 0, 0);
    drive(0, 1, SW, 32'h20, 32'h55AA55AA, 0, 1, 0);
    drive(1, 1, SW, 32'h20, 32'h55AA55AA, 0, 0, 0);
    tests++;
    if ({data_req, stallM} !== 2'b01) begin
      fails++; $display("FAIL rstmid_data: req=%b stall=%b, expected 0 1", data_req, stallM);
    end
    idle();
    tests++;
    if ({data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, stallM} !== '0) begin
      fails++; $display("FAIL rstmid_clear: req=%b addr=%h wdata=%h wstrb=%b stall=%b, expected all 0",
                        data_req, data_addr, data_wdata, data_wstrb, stallM);
    end
    idle(0, 1);
    idle();
    tests++;
    if ({data_req, stallM} !== 2'b00) begin
      fails++; $display("FAIL late_data_ok: req=%b stall=%b, expected 0 0", data_req, stallM);
    end
  endtask
  task automatic test_back_to_back;
    int hs = 0;
    drive(0, 1, SW, 32'h100, 32'hA, 0, 0, 0);
    drive(0, 1, SW, 32'h100, 32'hA, 0, 1, 0);
    hs += int'(data_req & data_addr_ok);
    tests++;
    if (data_addr !== 32'h100) begin
      fails++; $display("FAIL b2b_first: addr=%h, expected 100", data_addr);
    end
    drive(0, 1, SW, 32'h100, 32'hA, 0, 1, 1);
    hs += int'(data_req & data_addr_ok);
    drive(0, 1, SW, 32'h104, 32'hB, 0, 0, 0);
    tests++;
    if ({data_req, stallM} !== 2'b01) begin
      fails++; $display("FAIL b2b_second_start: req=%b stall=%b, expected 0 1", data_req, stallM);
    end
    for (int i = 0; i < 20 && !(data_req && data_addr_ok); i++) begin
      drive(0, 1, SW, 32'h104, 32'hB, 0, $urandom_range(0, 2) == 0, 1);
      hs += int'(data_req & data_addr_ok);
      if (data_req && data_addr !== 32'h104) begin
        tests++; fails++; $display("FAIL b2b_second_addr: addr=%h, expected 104", data_addr);
      end
    end
    idle();
    tests++;
    if (hs !== 2) begin
      fails++; $display("FAIL b2b_handshakes: got %0d, expected 2", hs);
    end
  endtask
  task automatic test_random;
    logic [7:0] ops [4] = '{SB, SH, SW, NOP};
    logic busy = 0, acc = 0, e_ades, e_start, e_stall, e_req, r, s, f, ao, dk, ok;
    logic [31:0] e_addr = 0, e_wdata = 0, a, d;
    logic [3:0] e_wstrb = 0;
    logic [1:0] e_size = 0;
    logic [7:0] o;
    drive(1, 0, NOP, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 63) == 0; s = $urandom_range(0, 2) != 0; o = ops[$urandom_range(0, 3)];
      a = $urandom; d = $urandom; f = $urandom_range(0, 7) == 0;
      ao = $urandom_range(0, 2) == 0; dk = $urandom_range(0, 2) == 0;
      drive(r, s, o, a, d, f, ao, dk);
      ok = o == SB || o == SH || o == SW;
      e_ades = s && ((o == SH && a[0]) || (o == SW && a % 4 != 0));
      e_start = s && ok && !e_ades && !f && !busy;
      e_req = busy && !acc;
      e_stall = e_start || e_req || (busy && acc && !dk);
      tests++;
      if (adesM !== e_ades || badvaddrM !== (e_ades ? a : 0) || stallM !== e_stall || data_req !== e_req || data_wr !== e_req ||
          data_addr !== e_addr || data_wdata !== e_wdata || data_wstrb !== e_wstrb || data_size !== e_size) begin
        fails++;
        if (fails < 20) $display("FAIL rand c%0d: ades=%b/%b badv=%h stall=%b/%b req=%b/%b addr=%h/%h wdata=%h/%h wstrb=%b/%b size=%0d/%0d (got/expected)",
                                 c, adesM, e_ades, badvaddrM, stallM, e_stall, data_req, e_req, data_addr, e_addr,
                                 data_wdata, e_wdata, data_wstrb, e_wstrb, data_size, e_size);
      end
      if (r) begin
        busy = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0; e_size = 0;
      end else if (e_start) begin
        busy = 1; acc = 0; e_addr = a;
        e_wdata = o == SB ? {24'b0, d[7:0]} * 32'h01010101 : o == SH ? {16'b0, d[15:0]} * 32'h00010001 : d;
        e_wstrb = o == SB ? 4'(1 << (a % 4)) : o == SH ? 4'(3 << (a & 2)) : 4'hF;
        e_size = o == SB ? 2'd0 : o == SH ? 2'd1 : 2'd2;
      end else if (busy && !acc && ao) begin
        busy = !dk; acc = 1;
      end else if (busy && acc && dk) busy = 0;
    end
    idle();
  endtask
  initial begin
    test_reset;
    test_sb;
    test_sh_delay;
    test_ades;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
